// File: rtl/axil_umem_wbridge.sv
// axil_umem_wbridge
// AXI4-Lite write slave that pairs independent AW/W beats and turns each
// transaction into a single-cycle 32-bit write strobe on the unified memory's
// AXI port, then returns a B response. One transaction is in flight at a time.
//
// Optional feature: define AXIL_UMEM_RANGE_CHECK_EN to reject addresses
// outside [BASE_ADDR, BASE_ADDR + WIN_SIZE) with SLVERR. When undefined,
// every address is forwarded and only a partial strobe produces SLVERR.
module axil_umem_wbridge #(
    parameter logic [31:0] BASE_ADDR = 32'hA0000100,
    parameter int unsigned WIN_SIZE  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    // AW channel
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    // W channel
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    // B channel
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    // Unified memory AXI port
    output logic [31:0] axi_mem_addr,
    output logic [31:0] axi_mem_data,
    output logic        axi_mem_w
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_UMEM_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    // Window bounds carried in 33 bits so BASE_ADDR + WIN_SIZE cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(WIN_SIZE);

    state_t      state;

    // Holding registers for the two request channels.
    logic        aw_full;
    logic [31:0] aw_addr_q;
    logic        w_full;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    // Hold contents as they will be after this edge, so a beat arriving in
    // the same cycle as its partner (or together with it) is evaluated at once.
    logic        aw_take;
    logic        w_take;
    logic        aw_full_n;
    logic        w_full_n;
    logic [31:0] addr_n;
    logic [31:0] data_n;
    logic [3:0]  strb_n;
    logic        strb_err;
    logic        range_err;
    logic        txn_err;

    assign aw_take   = awvalid & awready;
    assign w_take    = wvalid & wready;
    assign aw_full_n = aw_full | aw_take;
    assign w_full_n  = w_full | w_take;
    assign addr_n    = aw_take ? awaddr : aw_addr_q;
    assign data_n    = w_take ? wdata : w_data_q;
    assign strb_n    = w_take ? wstrb : w_strb_q;

    assign strb_err  = (strb_n != 4'hF);
    assign range_err = ({1'b0, addr_n} < WIN_LO) || ({1'b0, addr_n} >= WIN_HI);
    assign txn_err   = strb_err | (RANGE_CHECK & range_err);

    // Capture beats, sequence IDLE -> WRITE -> RESP, and register all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            aw_full      <= 1'b0;
            aw_addr_q    <= '0;
            w_full       <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            axi_mem_w    <= 1'b0;
            axi_mem_addr <= '0;
            axi_mem_data <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would let later statements see
            // half-updated state and make the result order-dependent.
            case (state)
                S_IDLE: begin
                    if (aw_take) begin
                        aw_full   <= 1'b1;
                        aw_addr_q <= awaddr;
                    end
                    if (w_take) begin
                        w_full   <= 1'b1;
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                    if (aw_full_n && w_full_n) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        if (txn_err) begin
                            state  <= S_RESP;
                            bvalid <= 1'b1;
                            bresp  <= RESP_SLVERR;
                        end else begin
                            state        <= S_WRITE;
                            axi_mem_w    <= 1'b1;
                            axi_mem_addr <= addr_n;
                            axi_mem_data <= data_n;
                        end
                    end else begin
                        awready <= ~aw_full_n;
                        wready  <= ~w_full_n;
                    end
                end

                S_WRITE: begin
                    axi_mem_w <= 1'b0;
                    state     <= S_RESP;
                    bvalid    <= 1'b1;
                    bresp     <= RESP_OKAY;
                end

                S_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_full <= 1'b0;
                        w_full  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    axi_mem_w <= 1'b0;
                    bvalid    <= 1'b0;
                    aw_full   <= 1'b0;
                    w_full    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_umem_wbridge.sv
// Self-checking bench for axil_umem_wbridge: directed protocol scenarios
// followed by randomized transactions, all checked against a transaction-level
// reference model (error rule, expected strobe cycle, last-written address/data).
module tb_axil_umem_wbridge;

    localparam logic [31:0] BASE = 32'hA0000100;
    localparam longint      WIN  = 256;

`ifdef AXIL_UMEM_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [31:0] axi_mem_addr;
    logic [31:0] axi_mem_data;
    logic        axi_mem_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the memory port should currently show.
    logic [31:0] m_last_addr = '0;
    logic [31:0] m_last_data = '0;

    logic prev_w = 1'b0;

    axil_umem_wbridge #(
        .BASE_ADDR(BASE),
        .WIN_SIZE (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .axi_mem_addr(axi_mem_addr),
        .axi_mem_data(axi_mem_data),
        .axi_mem_w   (axi_mem_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level rule: partial strobes fail; out-of-window fails when enabled.
    function automatic bit model_err(input logic [31:0] a, input logic [3:0] s);
        longint la;
        la = longint'(a);
        if (s != 4'hF) return 1'b1;
        if (RANGE_ON && (la < longint'(BASE) || la >= longint'(BASE) + WIN)) return 1'b1;
        return 1'b0;
    endfunction

    // The write strobe must never be high on two consecutive cycles.
    always @(negedge clk) begin
        if (rst_n) chk("no_back_to_back_strobe", {31'b0, prev_w & axi_mem_w}, 32'd0);
        prev_w <= rst_n ? axi_mem_w : 1'b0;
    end

    task automatic wait_idle(input string name);
        int waited = 0;
        while (!(awready === 1'b1 && wready === 1'b1) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({name, ":idle_wait"}, {31'b0, awready & wready}, 32'd1);
    endtask

    // Runs one transaction starting at a negedge; AW/W/B delays in cycles.
    // Checks, at every negedge, strobe timing, held memory address/data,
    // bvalid window, bresp, and ready deassertion while busy.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly, input int b_dly, input string name);
        bit err;
        bit aw_done, w_done, resp_fire, fin, exp_w, exp_bv;
        int hs_k, bv_cnt;
        err = model_err(a, s);
        aw_done = 0; w_done = 0; resp_fire = 0; fin = 0;
        hs_k = -1; bv_cnt = 0;
        wait_idle(name);
        for (int k = 0; k < 60 && !fin; k++) begin
            if (resp_fire) begin
                chk({name, ":bvalid_drop"}, {31'b0, bvalid}, 32'd0);
                chk({name, ":awready_back"}, {31'b0, awready}, 32'd1);
                chk({name, ":wready_back"}, {31'b0, wready}, 32'd1);
                fin = 1;
            end else begin
                exp_w = (hs_k >= 0) && !err && (k == hs_k + 1);
                chk({name, ":mem_w"}, {31'b0, axi_mem_w}, {31'b0, exp_w});
                if (exp_w) begin
                    m_last_addr = a;
                    m_last_data = d;
                end
                chk({name, ":mem_addr"}, axi_mem_addr, m_last_addr);
                chk({name, ":mem_data"}, axi_mem_data, m_last_data);
                exp_bv = (hs_k >= 0) && (k >= hs_k + (err ? 1 : 2));
                chk({name, ":bvalid"}, {31'b0, bvalid}, {31'b0, exp_bv});
                if (exp_bv) begin
                    chk({name, ":bresp"}, {30'b0, bresp}, err ? 32'd2 : 32'd0);
                    bv_cnt++;
                end
                if (aw_done && !w_done) chk({name, ":awready_wait"}, {31'b0, awready}, 32'd0);
                if (w_done && !aw_done) chk({name, ":wready_wait"}, {31'b0, wready}, 32'd0);
                if (hs_k >= 0) chk({name, ":ready_busy"}, {30'b0, awready, wready}, 32'd0);

                awvalid = !aw_done && (k >= aw_dly);
                awaddr  = a;
                wvalid  = !w_done && (k >= w_dly);
                wdata   = d;
                wstrb   = s;
                if (awvalid && awready) aw_done = 1;
                if (wvalid && wready)   w_done  = 1;
                if (hs_k < 0 && aw_done && w_done) hs_k = k;
                bready = (bv_cnt > b_dly) || (b_dly == 0);
                if (bvalid && bready) resp_fire = 1;
            end
            if (!fin) @(negedge clk);
        end
        chk({name, ":completed"}, {31'b0, fin}, 32'd1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst:awready", {31'b0, awready}, 32'd0);
        chk("rst:wready", {31'b0, wready}, 32'd0);
        chk("rst:bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst:bresp", {30'b0, bresp}, 32'd0);
        chk("rst:mem_w", {31'b0, axi_mem_w}, 32'd0);
        chk("rst:mem_addr", axi_mem_addr, 32'd0);
        chk("rst:mem_data", axi_mem_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst:awready", {31'b0, awready}, 32'd1);
        chk("post_rst:wready", {31'b0, wready}, 32'd1);

        // Directed scenarios
        txn(32'hA0000104, 32'hDEADBEEF, 4'hF, 0, 0, 0, "same_cycle");
        txn(32'hA00001FE, 32'h11223344, 4'hF, 0, 3, 0, "aw_first");
        txn(32'hA0000110, 32'h55AA55AA, 4'h3, 0, 0, 0, "partial_strb");
        txn(32'hA0000200, 32'hCAFEF00D, 4'hF, 1, 0, 0, "above_window");
        txn(32'hA00000FC, 32'h0F0F0F0F, 4'hF, 0, 0, 0, "below_window");
        txn(32'hA0000120, 32'h0BADC0DE, 4'hF, 0, 0, 5, "bready_low");
        txn(32'hA0000130, 32'h12345678, 4'hF, 2, 0, 1, "w_first");

        // Reset pulsed during WRITE
        wait_idle("rst_write");
        awvalid = 1'b1; awaddr = 32'hA0000140;
        wvalid  = 1'b1; wdata  = 32'h89ABCDEF; wstrb = 4'hF;
        bready  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("rst_write:strobe_before", {31'b0, axi_mem_w}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_write:mem_w_drop", {31'b0, axi_mem_w}, 32'd0);
        chk("rst_write:bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_write:awready", {31'b0, awready}, 32'd0);
        chk("rst_write:mem_addr", axi_mem_addr, 32'd0);
        chk("rst_write:mem_data", axi_mem_data, 32'd0);
        m_last_addr = '0;
        m_last_data = '0;
        bready = 1'b0;
        @(negedge clk);
        chk("rst_write:no_bvalid_later", {31'b0, bvalid}, 32'd0);
        rst_n = 1'b1;
        txn(32'hA0000150, 32'h13579BDF, 4'hF, 0, 0, 0, "after_rst");

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rd;
            logic [3:0]  rs;
            case ($urandom_range(0, 3))
                0: ra = BASE + 32'($urandom_range(0, 255));
                1: ra = BASE - 32'($urandom_range(1, 4096));
                2: ra = BASE + 32'd256 + 32'($urandom_range(0, 4096));
                default: ra = $urandom;
            endcase
            rd = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            txn(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), "random");
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
